// File: rtl/memory_turn_controller.sv
// Two-player memory (pairs) game controller: turn sequencing, scoring and winner decode.
// Optional per-turn countdown with timeout enabled by defining TURN_TIMER_EN.
module memory_turn_controller #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int TURN_SECS     = 15,
    parameter int SHOW_TICKS    = 50000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_btn,
    input  logic        click_e,
    input  logic [3:0]  sel_idx,
    input  logic [47:0] deck_i,
    output logic [15:0] card_faceup_o,
    output logic [15:0] card_removed_o,
    output logic        current_player_o,
    output logic [3:0]  p1_pairs_o,
    output logic [3:0]  p2_pairs_o,
    output logic [3:0]  time_left_o,
    output logic        show_winner_o,
    output logic [1:0]  winner_code_o
);

    typedef enum logic [2:0] {IDLE, PICK1, PICK2, SHOW, CHECK, OVER} state_t;

    localparam logic [3:0] TURN_RELOAD = 4'(TURN_SECS);
    localparam int         SHOW_W      = $clog2(SHOW_TICKS + 1) + 1;
    localparam logic [SHOW_W-1:0] SHOW_LOAD = SHOW_W'(SHOW_TICKS);
    localparam logic [3:0] MAX_PAIRS   = 4'd8;

    state_t             state_q, state_d;
    logic [15:0]        faceup_q, faceup_d;
    logic [15:0]        removed_q, removed_d;
    logic               player_q, player_d;
    logic [3:0]         p1_q, p1_d;
    logic [3:0]         p2_q, p2_d;
    logic [3:0]         idx1_q, idx1_d;
    logic [3:0]         idx2_q, idx2_d;
    logic [SHOW_W-1:0]  show_cnt_q, show_cnt_d;
    logic [3:0]         time_left_q, time_left_d;

    logic [2:0] sym [16];
    logic       click_ok;
    logic       picking;
    logic       timeout;
    logic       wrap;
    logic       reload;
    logic [4:0] pair_sum;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_sym
            assign sym[gi] = deck_i[3*gi +: 3];
        end
    endgenerate

    assign click_ok = click_e && !faceup_q[sel_idx] && !removed_q[sel_idx];
    assign picking  = (state_q == PICK1) || (state_q == PICK2);

`ifdef TURN_TIMER_EN
    localparam int PRESC_W = $clog2(TICKS_PER_SEC + 1) + 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICKS_PER_SEC - 1);

    logic [PRESC_W-1:0] presc_q, presc_d;

    assign wrap    = picking && (presc_q == PRESC_MAX);
    assign timeout = wrap && (time_left_q == 4'd1);

    always_comb begin
        presc_d = presc_q;
        if (reload || wrap) begin
            presc_d = '0;
        end else if (picking) begin
            presc_d = presc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end
`else
    assign wrap    = 1'b0;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        faceup_d    = faceup_q;
        removed_d   = removed_q;
        player_d    = player_q;
        p1_d        = p1_q;
        p2_d        = p2_q;
        idx1_d      = idx1_q;
        idx2_d      = idx2_q;
        show_cnt_d  = show_cnt_q;
        reload      = 1'b0;
        pair_sum    = '0;

        case (state_q)
            IDLE, OVER: begin
                if (start_btn) begin
                    state_d    = PICK1;
                    faceup_d   = '0;
                    removed_d  = '0;
                    player_d   = 1'b0;
                    p1_d       = '0;
                    p2_d       = '0;
                    show_cnt_d = '0;
                    reload     = 1'b1;
                end
            end
            PICK1, PICK2: begin
                // A timeout takes priority over any click in the same cycle.
                if (timeout) begin
                    state_d  = PICK1;
                    faceup_d = '0;
                    player_d = ~player_q;
                    reload   = 1'b1;
                end else if (click_ok) begin
                    faceup_d[sel_idx] = 1'b1;
                    if (state_q == PICK1) begin
                        idx1_d  = sel_idx;
                        state_d = PICK2;
                    end else begin
                        idx2_d     = sel_idx;
                        show_cnt_d = SHOW_LOAD;
                        state_d    = SHOW;
                    end
                end
            end
            SHOW: begin
                if (show_cnt_q <= SHOW_W'(1)) begin
                    state_d = CHECK;
                end else begin
                    show_cnt_d = show_cnt_q - 1'b1;
                end
            end
            CHECK: begin
                faceup_d[idx1_q] = 1'b0;
                faceup_d[idx2_q] = 1'b0;
                reload           = 1'b1;
                if (sym[idx1_q] == sym[idx2_q]) begin
                    removed_d[idx1_q] = 1'b1;
                    removed_d[idx2_q] = 1'b1;
                    if (!player_q) begin
                        p1_d = (p1_q >= MAX_PAIRS) ? MAX_PAIRS : p1_q + 4'd1;
                    end else begin
                        p2_d = (p2_q >= MAX_PAIRS) ? MAX_PAIRS : p2_q + 4'd1;
                    end
                end else begin
                    player_d = ~player_q;
                end
                pair_sum = {1'b0, p1_d} + {1'b0, p2_d};
                state_d  = (pair_sum >= 5'd8) ? OVER : PICK1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Without the timer a decrement never happens, so the register just holds the reload value.
    always_comb begin
        time_left_d = time_left_q;
        if (reload) begin
            time_left_d = TURN_RELOAD;
        end else if (wrap) begin
            time_left_d = time_left_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            faceup_q    <= '0;
            removed_q   <= '0;
            player_q    <= 1'b0;
            p1_q        <= '0;
            p2_q        <= '0;
            idx1_q      <= '0;
            idx2_q      <= '0;
            show_cnt_q  <= '0;
            time_left_q <= TURN_RELOAD;
        end else begin
            state_q     <= state_d;
            faceup_q    <= faceup_d;
            removed_q   <= removed_d;
            player_q    <= player_d;
            p1_q        <= p1_d;
            p2_q        <= p2_d;
            idx1_q      <= idx1_d;
            idx2_q      <= idx2_d;
            show_cnt_q  <= show_cnt_d;
            time_left_q <= time_left_d;
        end
    end

    always_comb begin
        winner_code_o = 2'd0;
        if (state_q == OVER) begin
            if (p1_q > p2_q) begin
                winner_code_o = 2'd1;
            end else if (p2_q > p1_q) begin
                winner_code_o = 2'd2;
            end else begin
                winner_code_o = 2'd3;
            end
        end
    end

    assign show_winner_o    = (state_q == OVER);
    assign card_faceup_o    = faceup_q;
    assign card_removed_o   = removed_q;
    assign current_player_o = player_q;
    assign p1_pairs_o       = p1_q;
    assign p2_pairs_o       = p2_q;
    assign time_left_o      = time_left_q;

endmodule
